// File: rtl/usb_tx_sequencer.sv
// USB 2.0 transmit sequencer: SYNC, LSB-first data, bit stuffing and EOP
// framing in front of the NRZI encoder, one NRZ bit per gclk.
module usb_tx_sequencer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6,
  parameter int         EOP_SE0_BITS = 2,
  parameter int         EOP_J_BITS   = 1
) (
  input  logic       gclk,
  input  logic       reset_l,
  input  logic       pkt_start,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  input  logic       tx_last,
  output logic       tx_byte_ready,
  output logic       start_txd,
  output logic       enc_data,
  output logic       tx_se0,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_BITS - 1);
  localparam logic [3:0] J_LAST = 4'(EOP_J_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    hold_q, hold_n;
  logic          full_q, full_n;
  logic          last_q, last_n;
  logic [OW-1:0] ones_q, ones_n;
  logic [3:0]    eop_q, eop_n;

  logic start_n, enc_n, se0_n, busy_n;
  logic done_n, unr_n, ready_n;
  logic xfer, avail, last_eff;
  logic emit, nbit;
  logic [7:0] byte_in;

  assign xfer     = tx_byte_valid & tx_byte_ready;
  assign avail    = full_q | xfer;
  assign byte_in  = full_q ? hold_q : tx_byte;
  assign last_eff = last_q | (xfer & tx_last);

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    hold_n  = hold_q;
    full_n  = full_q;
    last_n  = last_q;
    ones_n  = ones_q;
    eop_n   = eop_q;
    start_n = start_txd;
    enc_n   = enc_data;
    se0_n   = tx_se0;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    unr_n   = 1'b0;
    emit    = 1'b0;
    nbit    = 1'b0;
    if (xfer) begin
      hold_n = tx_byte;
      full_n = 1'b1;
      last_n = tx_last;
    end
    unique case (state_q)
      IDLE: begin
        start_n = 1'b0;
        enc_n   = 1'b1;
        se0_n   = 1'b0;
        busy_n  = 1'b0;
        full_n  = 1'b0;
        last_n  = 1'b0;
        ones_n  = '0;
        if (pkt_start) begin
          state_n = SYNC;
          bit_n   = 3'd0;
          sh_n    = SYNC_PATTERN >> 1;
          busy_n  = 1'b1;
          emit    = 1'b1;
          nbit    = SYNC_PATTERN[0];
        end
      end
      SYNC, DATA, STUFF: begin
        if (bit_q == 3'd7 && !avail && !last_q) begin
          // Underrun cuts straight to SE0, skipping any owed stuff bit
          state_n = EOP_SE0;
          unr_n   = 1'b1;
        end else if (ones_q == ONES_MAX) begin
          state_n = STUFF;
          start_n = 1'b1;
          enc_n   = 1'b0;
          ones_n  = '0;
        end else if (bit_q != 3'd7) begin
          state_n = (state_q == STUFF) ? DATA : state_q;
          bit_n   = bit_q + 3'd1;
          sh_n    = sh_q >> 1;
          emit    = 1'b1;
          nbit    = sh_q[0];
        end else if (avail) begin
          // Byte arriving on the boundary edge bypasses the hold register
          state_n = DATA;
          bit_n   = 3'd0;
          sh_n    = byte_in >> 1;
          full_n  = 1'b0;
          last_n  = last_eff;
          emit    = 1'b1;
          nbit    = byte_in[0];
        end else begin
          state_n = EOP_SE0;
        end
        if (state_n == EOP_SE0) begin
          start_n = 1'b0;
          se0_n   = 1'b1;
          enc_n   = 1'b1;
          eop_n   = 4'd0;
          ones_n  = '0;
        end
      end
      EOP_SE0: begin
        if (eop_q == SE0_LAST) begin
          state_n = EOP_J;
          se0_n   = 1'b0;
          eop_n   = 4'd0;
          done_n  = (J_LAST == 4'd0);
        end else begin
          eop_n = eop_q + 4'd1;
        end
      end
      EOP_J: begin
        if (eop_q == J_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          last_n  = 1'b0;
        end else begin
          eop_n  = eop_q + 4'd1;
          done_n = (eop_n == J_LAST);
        end
      end
      default: state_n = IDLE;
    endcase
    if (emit) begin
      start_n = 1'b1;
      enc_n   = nbit;
      ones_n  = nbit ? ones_q + 1'b1 : '0;
    end
    ready_n = !full_n && !last_n &&
              (state_n == SYNC || state_n == DATA ||
               state_n == STUFF);
  end

  always_ff @(posedge gclk) begin
    if (!reset_l) begin
      state_q       <= IDLE;
      bit_q         <= 3'd0;
      sh_q          <= 8'd0;
      hold_q        <= 8'd0;
      full_q        <= 1'b0;
      last_q        <= 1'b0;
      ones_q        <= '0;
      eop_q         <= 4'd0;
      start_txd     <= 1'b0;
      enc_data      <= 1'b1;
      tx_se0        <= 1'b0;
      tx_byte_ready <= 1'b0;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      state_q       <= state_n;
      bit_q         <= bit_n;
      sh_q          <= sh_n;
      hold_q        <= hold_n;
      full_q        <= full_n;
      last_q        <= last_n;
      ones_q        <= ones_n;
      eop_q         <= eop_n;
      start_txd     <= start_n;
      enc_data      <= enc_n;
      tx_se0        <= se0_n;
      tx_byte_ready <= ready_n;
      tx_busy       <= busy_n;
      tx_done       <= done_n;
      tx_underrun   <= unr_n;
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: packet framing, stuffing,
// underrun, mid-packet reset and backpressure.
module tb_usb_tx_sequencer;

  logic       gclk = 1'b0;
  logic       reset_l;
  logic       pkt_start;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_last;
  logic       tx_byte_ready;
  logic       start_txd;
  logic       enc_data;
  logic       tx_se0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  always #5 gclk = ~gclk;

  usb_tx_sequencer dut (
    .gclk          (gclk),
    .reset_l       (reset_l),
    .pkt_start     (pkt_start),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_last       (tx_last),
    .tx_byte_ready (tx_byte_ready),
    .start_txd     (start_txd),
    .enc_data      (enc_data),
    .tx_se0        (tx_se0),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_underrun   (tx_underrun)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic       q_last;

  string      got;
  int         first_start, last_start;
  int         se0_first, se0_cnt;
  int         done_rel, done_cnt;
  int         unr_rel, unr_cnt;
  int         late_ready;
  logic       ready2, busy_after, busy_end;
  logic [6:0] snap;

  function automatic logic [6:0] outs();
    return {start_txd, enc_data, tx_se0,
            tx_byte_ready, tx_busy, tx_done,
            tx_underrun};
  endfunction

  task automatic chk_i(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(string tag, string obs, string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s got=%s exp=%s", tag, obs, exp);
    end
  endtask

  // rel 0 is the cycle pkt_start is driven; rel r samples cycle k+r
  task automatic run(input int budget, input int rst_at,
                     input int pulse_at);
    got = "";
    first_start = -1; last_start = -1;
    se0_first = -1; se0_cnt = 0;
    done_rel = -1; done_cnt = 0;
    unr_rel = -1; unr_cnt = 0;
    late_ready = 0;
    ready2 = 1'bx; busy_after = 1'bx;
    busy_end = 1'bx; snap = 'x;
    @(negedge gclk);
    pkt_start = 1'b1;
    for (int r = 1; r <= budget; r++) begin
      @(negedge gclk);
      pkt_start = (r == pulse_at);
      reset_l = (r != rst_at);
      if (start_txd) begin
        if (first_start < 0) first_start = r;
        last_start = r;
        got = {got, (enc_data ? "1" : "0")};
      end
      if ((se0_cnt > 0 || unr_cnt > 0) && tx_byte_ready)
        late_ready++;
      if (tx_se0) begin
        if (se0_first < 0) se0_first = r;
        se0_cnt++;
      end
      if (tx_underrun) begin
        unr_cnt++;
        unr_rel = r;
      end
      if (r == 2) ready2 = tx_byte_ready;
      if (done_cnt > 0 && r == done_rel + 1)
        busy_after = tx_busy;
      if (tx_done) begin
        done_cnt++;
        done_rel = r;
      end
      busy_end = tx_busy;
      if (rst_at > 0 && r == rst_at + 1) snap = outs();
      tx_byte_valid = (q.size() > 0);
      if (tx_byte_valid) tx_byte = q[0];
      tx_last = q_last && (q.size() == 1);
      if (tx_byte_valid && tx_byte_ready) void'(q.pop_front());
      if (rst_at > 0 && r == rst_at + 1) break;
      if (done_cnt > 0 && r >= done_rel + 3) break;
    end
    pkt_start = 1'b0;
    tx_byte_valid = 1'b0;
    tx_last = 1'b0;
    reset_l = 1'b1;
    q.delete();
    repeat (2) @(negedge gclk);
  endtask

  initial begin
    reset_l = 1'b0;
    pkt_start = 1'b0;
    tx_byte = 8'h00;
    tx_byte_valid = 1'b0;
    tx_last = 1'b0;
    q_last = 1'b0;
    repeat (3) @(negedge gclk);
    chk_i("rst_outs", int'(outs()), int'(7'b0100000));
    reset_l = 1'b1;
    @(negedge gclk);
    chk_i("idle_outs", int'(outs()), int'(7'b0100000));

    // 1: single 0x00, last
    q = '{8'h00}; q_last = 1'b1;
    run(60, -1, -1);
    chk_s("t1_stream", got, "0000000100000000");
    chk_i("t1_first", first_start, 1);
    chk_i("t1_lastst", last_start, 16);
    chk_i("t1_se0_at", se0_first, 17);
    chk_i("t1_se0_n", se0_cnt, 2);
    chk_i("t1_done_at", done_rel, 19);
    chk_i("t1_done_n", done_cnt, 1);
    chk_i("t1_busy_off", int'(busy_after), 0);
    chk_i("t1_ready2", int'(ready2), 0);

    // 2: 0xFF, stuff after fifth data 1
    q = '{8'hFF}; q_last = 1'b1;
    run(60, -1, -1);
    chk_s("t2_stream", got, "00000001111110111");
    chk_i("t2_lastst", last_start, 17);
    chk_i("t2_se0_at", se0_first, 18);
    chk_i("t2_done_at", done_rel, 20);

    // 3: 0x3F, 0xFC with trailing stuff before EOP
    q = '{8'h3F, 8'hFC}; q_last = 1'b1;
    run(60, -1, -1);
    chk_s("t3_stream", got,
          "00000001111110100001111110");
    chk_i("t3_se0_at", se0_first, 27);
    chk_i("t3_se0_n", se0_cnt, 2);
    chk_i("t3_done_at", done_rel, 29);

    // 4: 0x55 without last, then starve
    q = '{8'h55}; q_last = 1'b0;
    run(60, -1, -1);
    chk_s("t4_stream", got, "0000000110101010");
    chk_i("t4_unr_at", unr_rel, 17);
    chk_i("t4_unr_n", unr_cnt, 1);
    chk_i("t4_se0_at", se0_first, 17);
    chk_i("t4_se0_n", se0_cnt, 2);
    chk_i("t4_done_at", done_rel, 19);
    chk_i("t4_late_rdy", late_ready, 0);

    // 5: reset during 3rd data bit, then 0xA5
    q = '{8'h0F}; q_last = 1'b1;
    run(20, 11, -1);
    chk_s("t5_partial", got, "00000001111");
    chk_i("t5_rst_outs", int'(snap), int'(7'b0100000));
    chk_i("t5_no_done", done_cnt, 0);
    q = '{8'hA5}; q_last = 1'b1;
    run(60, -1, -1);
    chk_s("t5_stream", got, "0000000110100101");
    chk_i("t5_se0_at", se0_first, 17);
    chk_i("t5_done_at", done_rel, 19);

    // 6: stray pkt_start while busy, valid held high
    q = '{8'h12, 8'h34, 8'h56}; q_last = 1'b1;
    run(80, -1, 5);
    chk_s("t6_stream", got,
          {"00000001", "01001000",
           "00101100", "01101010"});
    chk_i("t6_ready2", int'(ready2), 0);
    chk_i("t6_se0_at", se0_first, 33);
    chk_i("t6_done_at", done_rel, 35);
    chk_i("t6_done_n", done_cnt, 1);
    chk_i("t6_busy_end", int'(busy_end), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
- Transmit-side controller that sequences the NRZI encoder (`nrzi_encode_ap`) for one USB 2.0 packet.
- Takes packet bytes over a valid/ready stream, prepends SYNC, serializes bytes LSB-first, inserts stuff bits, and appends EOP.
- Drives the encoder's `start_txd` and data input, one NRZ bit per gclk.
- Sits between the packet assembler (PID/payload/CRC source) and the encoder.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte sent LSB-first (bit stream 0000_0001).
- STUFF_LEN, 6, run of consecutive NRZ 1s that forces an inserted 0.
- EOP_SE0_BITS, 2, SE0 bit times in EOP.
- EOP_J_BITS, 1, J bit times after SE0 before done.

Ports:
- gclk  input  1  clock; all logic on posedge.
- reset_l  input  1  synchronous active-low reset.
- pkt_start  input  1  one-cycle request to begin a packet; sampled in IDLE only.
- tx_byte  input  8  packet byte, LSB transmitted first.
- tx_byte_valid  input  1  tx_byte/tx_last valid.
- tx_last  input  1  qualifies the transferred byte as the final byte.
- tx_byte_ready  output  1  sequencer accepts a byte this cycle.
- start_txd  output  1  encoder enable; high for SYNC, data and stuff bits.
- enc_data  output  1  NRZ bit to encoder tx_data_in.
- tx_se0  output  1  EOP SE0 indication to line driver.
- tx_busy  output  1  high from cycle after accepted pkt_start until done cycle, inclusive.
- tx_done  output  1  one-cycle pulse at packet end.
- tx_underrun  output  1  one-cycle pulse when a byte is needed and none is held.

Behaviour:
- All outputs are registered.
- Reset (reset_l=0 at posedge, wins over every other input):
  - state IDLE; hold register empty; ones_cnt=0; last_seen=0.
  - Outputs: start_txd=0, enc_data=1, tx_se0=0, tx_byte_ready=0, tx_busy=0, tx_done=0, tx_underrun=0.
  - Reset mid-packet aborts immediately, with no EOP.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - pkt_start=1 at cycle k → SYNC.
  - k+1..k+8: start_txd=1, enc_data = SYNC_PATTERN bit i in cycle k+1+i.
  - pkt_start in any other state is ignored.
- Byte holding register (1 deep):
  - tx_byte_ready=1 when hold is empty, state ∈ {SYNC, DATA, STUFF}, and last_seen=0.
  - Transfer occurs on valid&ready; tx_last is captured into last_seen.
- Shift register:
  - Loads from hold on the cycle after the last SYNC bit or bit 7 of the current byte is emitted.
  - Load is zero-latency: the next data bit follows with no gap, except for stuff.
- Byte boundary with hold empty:
  - last_seen=1 → EOP, after any pending stuff bit.
  - last_seen=0 → tx_underrun pulse, go to EOP_SE0 directly, with no pending stuff.
- Bit stuffing:
  - ones_cnt counts consecutive emitted 1s, including SYNC (ends at 1).
  - Any emitted 0, stuffed or data, clears ones_cnt.
  - When an emitted 1 makes ones_cnt==STUFF_LEN, the next cycle is STUFF: enc_data=0, start_txd=1, shifting paused.
  - Stuff is emitted even after the final data bit.
- EOP_SE0: start_txd=0, tx_se0=1, enc_data=1, for EOP_SE0_BITS cycles.
- EOP_J: start_txd=0, tx_se0=0, enc_data=1, for EOP_J_BITS cycles.
- Completion: tx_done=1 in the last EOP_J cycle; tx_busy falls the following cycle; state IDLE.
- A new pkt_start is accepted the cycle after tx_done.
- tx_byte_valid with ready=0 is held by the source (standard backpressure). A byte is never dropped or duplicated.

Test Plan:
1. pkt_start at k, single byte 0x00 with tx_last, presented at k+1 → enc_data 0000_0001 over k+1..k+8, then eight 0s over k+9..k+16; tx_se0=1 at k+17..k+18; tx_done at k+19; start_txd high exactly k+1..k+16.
2. Single byte 0xFF last → data stream 1,1,1,1,1,0(stuff),1,1,1 (9 cycles, start_txd high); ones_cnt reaches 6 on the fifth data 1 because of the trailing SYNC 1.
3. Bytes 0x3F then 0xFC (last) → stream 1,1,1,1,1,0s,1,0,0,0,0,1,1,1,1,1,1,0s, then SE0 ×2 and J; the second stuff bit is present before EOP.
4. Byte 0x55 without tx_last, then valid held low → tx_underrun pulse at the byte boundary cycle; no stuff bit; SE0 ×2, J, tx_done; no further ready.
5. reset_l=0 for one cycle during the 3rd data bit → next cycle all outputs at reset values, state IDLE; a following packet (0xA5 last) runs exactly as in scenario 1 timing.
6. pkt_start pulsed while busy, and tx_byte_valid held high continuously → second pkt_start is ignored; ready drops while hold is full; each byte is transmitted exactly once, in order.
